// File: rtl/data_cache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Optional statistics counters are enabled by DATA_CACHE_STATS_EN.
package data_cache_ctrl_pkg;

    localparam int WORD     = 16;
    localparam int MEMDELAY = 4;

    typedef enum logic [1:0] {
        IDLE,
        MISS_RD,
        WR_THRU,
        RESP
    } cache_state_t;

    // Tag field is sized for the narrowest geometry (LINES = 2); unused upper bits stay zero.
    typedef struct packed {
        logic            valid;
        logic [WORD-1:0] tag;
        logic [WORD-1:0] data;
    } line_t;

    function automatic logic [WORD-1:0] line_index(input logic [WORD-1:0] addr, input int lines);
        return addr & WORD'(lines - 1);
    endfunction

    function automatic logic [WORD-1:0] line_tag(input logic [WORD-1:0] addr, input int lines);
        return addr >> $clog2(lines);
    endfunction

endpackage

// File: rtl/data_cache_ctrl_cache_line_array.sv
// Valid/tag/data storage: combinational lookup, one synchronous write port.
// Reset clears every line, which invalidates the whole cache.
module cache_line_array
    import data_cache_ctrl_pkg::*;
#(
    parameter int LINES  = 8,
    parameter int ADDR_W = WORD,
    parameter int DATA_W = WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int IDX_W = $clog2(LINES);

    line_t             lines_q [LINES];
    line_t             lines_d [LINES];
    line_t             rd_line;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  wr_idx;

    assign rd_idx  = IDX_W'(line_index(WORD'(rd_addr), LINES));
    assign wr_idx  = IDX_W'(line_index(WORD'(wr_addr), LINES));
    assign rd_line = lines_q[rd_idx];
    assign rd_hit  = rd_line.valid && (rd_line.tag == line_tag(WORD'(rd_addr), LINES));
    assign rd_data = DATA_W'(rd_line.data);

    always_comb begin
        lines_d = lines_q;
        if (wr_en) begin
            lines_d[wr_idx].valid = 1'b1;
            lines_d[wr_idx].tag   = line_tag(WORD'(wr_addr), LINES);
            lines_d[wr_idx].data  = WORD'(wr_data);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                lines_q[i] <= '0;
            end
        end else begin
            lines_q <= lines_d;
        end
    end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through data cache controller with strobe/mfc memory handshake.
// DATA_CACHE_STATS_EN adds saturating hit/miss/store counters.
module data_cache_ctrl
    import data_cache_ctrl_pkg::*;
#(
    parameter int LINES  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rnotw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_pid,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_pid,
    output logic              mem_strobe,
    output logic              mem_rnotw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_mfc
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [15:0]       stat_hits,
    output logic [15:0]       stat_misses,
    output logic [15:0]       stat_writes
`endif
);

    cache_state_t      state_q, state_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_pid_q, rsp_pid_d;
    logic              mem_strobe_q, mem_strobe_d;
    logic              mem_rnotw_q, mem_rnotw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              pid_q, pid_d;

    logic              lk_hit;
    logic [DATA_W-1:0] lk_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

`ifdef DATA_CACHE_STATS_EN
    logic [15:0] stat_hits_q, stat_hits_d;
    logic [15:0] stat_misses_q, stat_misses_d;
    logic [15:0] stat_writes_q, stat_writes_d;
`endif

    cache_line_array #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_lines (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (req_addr),
        .rd_hit  (lk_hit),
        .rd_data (lk_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    always_comb begin
        state_d      = state_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_pid_d    = rsp_pid_q;
        mem_strobe_d = mem_strobe_q;
        mem_rnotw_d  = mem_rnotw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        pid_d        = pid_q;
        wr_en        = 1'b0;
        wr_addr      = req_addr;
        wr_data      = req_wdata;
`ifdef DATA_CACHE_STATS_EN
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        stat_writes_d = stat_writes_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    pid_d = req_pid;
                    if (req_rnotw && lk_hit) begin
                        // Hits stay in IDLE so consecutive hits stream at one per cycle.
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = lk_data;
                        rsp_pid_d   = req_pid;
`ifdef DATA_CACHE_STATS_EN
                        if (stat_hits_q != '1) stat_hits_d = stat_hits_q + 16'd1;
`endif
                    end else begin
                        state_d      = req_rnotw ? MISS_RD : WR_THRU;
                        mem_strobe_d = 1'b1;
                        mem_rnotw_d  = req_rnotw;
                        mem_addr_d   = req_addr;
                        mem_wdata_d  = req_wdata;
                        wr_en        = !req_rnotw && lk_hit;
`ifdef DATA_CACHE_STATS_EN
                        if (req_rnotw && stat_misses_q != '1) stat_misses_d = stat_misses_q + 16'd1;
                        if (!req_rnotw && stat_writes_q != '1) stat_writes_d = stat_writes_q + 16'd1;
`endif
                    end
                end
            end
            MISS_RD: begin
                if (mem_mfc) begin
                    wr_en        = 1'b1;
                    wr_addr      = mem_addr_q;
                    wr_data      = mem_rdata;
                    rsp_rdata_d  = mem_rdata;
                    mem_strobe_d = 1'b0;
                    state_d      = RESP;
                end
            end
            WR_THRU: begin
                if (mem_mfc) begin
                    rsp_rdata_d  = '0;
                    mem_strobe_d = 1'b0;
                    mem_rnotw_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_pid_d   = pid_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_pid_q    <= 1'b0;
            mem_strobe_q <= 1'b0;
            mem_rnotw_q  <= 1'b1;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            pid_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_pid_q    <= rsp_pid_d;
            mem_strobe_q <= mem_strobe_d;
            mem_rnotw_q  <= mem_rnotw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            pid_q        <= pid_d;
        end
    end

`ifdef DATA_CACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
            stat_writes_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
            stat_writes_q <= stat_writes_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
    assign stat_writes = stat_writes_q;
`endif

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_pid    = rsp_pid_q;
    assign mem_strobe = mem_strobe_q;
    assign mem_rnotw  = mem_rnotw_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Randomized bench for data_cache_ctrl against a word-level cache/memory model.
// Build with DATA_CACHE_STATS_EN to also cover the statistics counters.
module tb_data_cache_ctrl;

    localparam int MEMDELAY_TB = data_cache_ctrl_pkg::MEMDELAY;
    localparam int NLINES      = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid, req_ready, req_rnotw, req_pid;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_pid;
    logic [15:0] rsp_rdata;
    logic        mem_strobe, mem_rnotw;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = 16'h0;
    logic        mem_mfc = 1'b0;
`ifdef DATA_CACHE_STATS_EN
    logic [15:0] stat_hits, stat_misses, stat_writes;
    int          exp_hits = 0, exp_misses = 0, exp_writes = 0;
`endif

    data_cache_ctrl #(.LINES(NLINES), .ADDR_W(16), .DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rnotw  (req_rnotw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_pid    (req_pid),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_pid    (rsp_pid),
        .mem_strobe (mem_strobe),
        .mem_rnotw  (mem_rnotw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_mfc    (mem_mfc)
`ifdef DATA_CACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses),
        .stat_writes (stat_writes)
`endif
    );

    always #5 clk = ~clk;

    // Main memory as seen by the DUT, plus the model's view of it.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        ref_valid [NLINES];
    int          ref_tag   [NLINES];
    logic [15:0] ref_data  [NLINES];

    int n_checks = 0;
    int n_fail = 0;
    int rsp_pulses = 0;
    int exp_pulses = 0;
    int mem_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: mfc pulses in the MEMDELAY-th cycle the strobe is seen high.
    always @(posedge clk) begin
        #1;
        mem_mfc   = 1'b0;
        mem_rdata = 16'($urandom);
        if (mem_strobe === 1'b1) begin
            mem_cnt++;
            if (mem_cnt == MEMDELAY_TB) begin
                mem_mfc = 1'b1;
                if (mem_rnotw) mem_rdata = mem[mem_addr];
                else           mem[mem_addr] = mem_wdata;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) rsp_pulses++;
    end

    task automatic model_reset();
        for (int i = 0; i < NLINES; i++) ref_valid[i] = 1'b0;
`ifdef DATA_CACHE_STATS_EN
        exp_hits = 0; exp_misses = 0; exp_writes = 0;
`endif
    endtask

    // Issue one request, called at posedge+1; returns at posedge+1 of the response cycle.
    task automatic do_req(input logic rnotw, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic pid, input bit hold);
        int          idx, tag, lat, strobes, bad, wait_n, exp_lat, exp_strobes;
        bit          exp_hit;
        logic [15:0] exp_data;
        idx     = int'(addr) % NLINES;
        tag     = int'(addr) / NLINES;
        exp_hit = ref_valid[idx] && ref_tag[idx] == tag;
        if (rnotw) begin
            if (exp_hit) begin
                exp_data = ref_data[idx];
            end else begin
                exp_data       = ref_mem[addr];
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tag;
                ref_data[idx]  = exp_data;
            end
`ifdef DATA_CACHE_STATS_EN
            if (exp_hit) exp_hits++; else exp_misses++;
`endif
        end else begin
            exp_data      = 16'h0;
            ref_mem[addr] = wdata;
            if (exp_hit) ref_data[idx] = wdata;
`ifdef DATA_CACHE_STATS_EN
            exp_writes++;
`endif
        end
        exp_lat     = (rnotw && exp_hit) ? 1 : MEMDELAY_TB + 2;
        exp_strobes = (rnotw && exp_hit) ? 0 : MEMDELAY_TB;
        exp_pulses++;

        req_valid = 1'b1;
        req_rnotw = rnotw;
        req_addr  = addr;
        req_wdata = wdata;
        req_pid   = pid;
        wait_n = 0;
        while (req_ready !== 1'b1 && wait_n < 100) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check("accept_wait", 32'(wait_n < 100), 32'd1);
        @(posedge clk); #1;
        if (!hold) req_valid = 1'b0;
        lat = 1; strobes = 0; bad = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            if (mem_strobe === 1'b1) begin
                strobes++;
                if (mem_addr !== addr || mem_rnotw !== rnotw || (!rnotw && mem_wdata !== wdata)) bad++;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
        check("rsp_pid", 32'(rsp_pid), 32'(pid));
        check("strobe_cycles", 32'(strobes), 32'(exp_strobes));
        check("mem_drive", 32'(bad), 32'd0);
        check("ready_on_rsp", 32'(req_ready), 32'd1);
        check("strobe_low_on_rsp", 32'(mem_strobe), 32'd0);
    endtask

    logic [15:0] ra;
    int          sel, gap;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'((i * 7 + 3) ^ 32'h5A5A);
            ref_mem[i] = mem[i];
        end
        mem[16'h0010]     = 16'h1234;
        ref_mem[16'h0010] = 16'h1234;
        req_valid = 1'b0; req_rnotw = 1'b1; req_addr = '0; req_wdata = '0; req_pid = 1'b0;
        model_reset();

        #1 reset = 1'b1;
        #2;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_pid", 32'(rsp_pid), 32'd0);
        check("rst_strobe", 32'(mem_strobe), 32'd0);
        check("rst_mem_rnotw", 32'(mem_rnotw), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
`ifdef DATA_CACHE_STATS_EN
        check("rst_stat_hits", 32'(stat_hits), 32'd0);
        check("rst_stat_misses", 32'(stat_misses), 32'd0);
        check("rst_stat_writes", 32'(stat_writes), 32'd0);
`endif
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        do_req(1'b1, 16'h0010, 16'h0, 1'b0, 1'b0);   // fill 0x1234
        do_req(1'b1, 16'h0010, 16'h0, 1'b0, 1'b0);   // hit
        do_req(1'b0, 16'h0010, 16'hBEEF, 1'b0, 1'b0);
        do_req(1'b1, 16'h0010, 16'h0, 1'b0, 1'b0);   // hit on updated line
        do_req(1'b1, 16'h0018, 16'h0, 1'b0, 1'b0);   // conflict evicts 0x0010
        do_req(1'b1, 16'h0010, 16'h0, 1'b0, 1'b0);
        do_req(1'b1, 16'h0010, 16'h0, 1'b1, 1'b0);   // cross-thread hit
        do_req(1'b0, 16'h0200, 16'hCAFE, 1'b1, 1'b0); // store miss, no allocate
        do_req(1'b1, 16'h0200, 16'h0, 1'b0, 1'b0);
        do_req(1'b1, 16'h0100, 16'h0, 1'b0, 1'b1);   // request left valid through the miss
        do_req(1'b1, 16'h0100, 16'h0, 1'b0, 1'b0);
        do_req(1'b1, 16'hFFFF, 16'h0, 1'b1, 1'b0);
        do_req(1'b1, 16'hFFFF, 16'h0, 1'b0, 1'b0);

        // Abandon a load miss with reset two cycles into the memory access.
        req_valid = 1'b1; req_rnotw = 1'b1; req_addr = 16'h0300; req_pid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("strobe_before_reset", 32'(mem_strobe), 32'd1);
        reset = 1'b1;
        #1;
        check("strobe_async_drop", 32'(mem_strobe), 32'd0);
        check("ready_in_reset", 32'(req_ready), 32'd1);
        model_reset();
`ifdef DATA_CACHE_STATS_EN
        check("rst2_stat_hits", 32'(stat_hits), 32'd0);
        check("rst2_stat_misses", 32'(stat_misses), 32'd0);
        check("rst2_stat_writes", 32'(stat_writes), 32'd0);
`endif
        @(negedge clk) reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("no_rsp_after_abort", 32'(rsp_pulses), 32'(exp_pulses));
        do_req(1'b1, 16'h0300, 16'h0, 1'b0, 1'b0);   // must miss
        do_req(1'b1, 16'h0010, 16'h0, 1'b0, 1'b0);   // line invalidated by reset

        for (int k = 0; k < 200; k++) begin
            sel = $urandom_range(0, 6);
            case (sel)
                0:       ra = 16'h0010;
                1:       ra = 16'h0018;
                2:       ra = 16'hFFFF;
                3:       ra = 16'hFFF7;
                4:       ra = 16'h0200;
                default: ra = 16'($urandom_range(0, 31));
            endcase
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            do_req($urandom_range(0, 3) != 0, ra, 16'($urandom), 1'($urandom), 1'b0);
        end

        @(posedge clk); #1;
        check("rsp_pulse_count", 32'(rsp_pulses), 32'(exp_pulses));
`ifdef DATA_CACHE_STATS_EN
        check("stat_hits", 32'(stat_hits), 32'(exp_hits));
        check("stat_misses", 32'(stat_misses), 32'(exp_misses));
        check("stat_writes", 32'(stat_writes), 32'(exp_writes));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_cache_ctrl.md
Name: data_cache_ctrl

Overview:
- Direct-mapped, write-through data cache between the processor's ALU/data-memory stage (Load/Store) and the slow main memory (MEMDELAY-cycle strobe/mfc handshake).
- Accepts one request at a time from the two-thread pipeline and tags each response with the issuing pid.
- Read hits return in 1 cycle. Read misses and all writes go to memory and stall the requester through ready.

Parameters:
- LINES, 8, number of one-word cache lines; power of 2, at least 2.
- ADDR_W, 16, word address width.
- DATA_W, 16, word width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  processor request present
- req_ready  out  1  controller can accept a request this cycle
- req_rnotw  in  1  1 = load, 0 = store
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- req_pid  in  1  issuing thread
- rsp_valid  out  1  one-cycle pulse: load data or store acknowledge
- rsp_rdata  out  DATA_W  load result; 0 for stores
- rsp_pid  out  1  pid of the completed request
- mem_strobe  out  1  memory request, held until mem_mfc
- mem_rnotw  out  1  memory direction
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_mfc
- mem_mfc  in  1  memory function complete, 1-cycle pulse

Behaviour:
- Address split:
  - index = addr[log2(LINES)-1:0]
  - tag = addr[ADDR_W-1:log2(LINES)]
  - Per line: valid bit, tag, data word.
- Reset (asynchronous) forces:
  - all valid bits 0, state IDLE
  - req_ready = 1
  - rsp_valid = 0, rsp_rdata = 0, rsp_pid = 0
  - mem_strobe = 0, mem_rnotw = 1, mem_addr = 0, mem_wdata = 0
- req_ready = 1 only in IDLE. A request is accepted on a rising edge with req_valid && req_ready. The request is latched: addr, wdata, rnotw, pid.
- States: IDLE, MISS_RD, WR_THRU, RESP.
- IDLE, load hit:
  - rsp_valid = 1 next cycle with the line data.
  - Stay in IDLE, so back-to-back hits sustain 1 per cycle.
- IDLE, load miss:
  - Go to MISS_RD.
  - Next cycle: mem_strobe = 1, mem_rnotw = 1, mem_addr = latched addr.
- MISS_RD:
  - Hold strobe, rnotw and addr stable until mem_mfc is sampled high.
  - On mfc: write the line (valid = 1, tag, mem_rdata), drop strobe, go to RESP.
  - rsp_rdata = mem_rdata.
- IDLE, store:
  - If the line hits, update its data in the same edge. No allocate on a store miss.
  - Go to WR_THRU with strobe = 1, mem_rnotw = 0, addr and wdata driven from the latched request.
- WR_THRU: on mfc, drop strobe and go to RESP. rsp_rdata = 0.
- RESP:
  - rsp_valid = 1 for exactly one cycle, rsp_pid = latched pid.
  - Go to IDLE; req_ready returns 1 in that same cycle.
- mem_mfc sampled in IDLE or RESP is ignored. mfc is never sampled in the cycle strobe rises.
- Miss latency: 1 (accept) + memory delay + 1 (RESP). With MEMDELAY = 4 a load miss gives rsp_valid 6 cycles after acceptance.
- Both pids share the cache; the tag carries no pid. Cross-thread hits are legal.
- req_valid asserted while req_ready = 0 is not accepted. The requester must hold the request stable.
- Reset mid-miss or mid-write:
  - strobe drops immediately and the operation is abandoned, with no response.
  - A store in WR_THRU may already have updated its cache line; this is cleared by the valid reset.
- Wrap-around: address 16'hFFFF maps to index LINES-1 with an all-ones tag. No special casing.

Optional Feature:
- Macro: DATA_CACHE_STATS_EN.
- When defined, add three outputs, all asynchronously reset to 0 and saturating at all-ones:
  - stat_hits, 16 bits: +1 per load hit
  - stat_misses, 16 bits: +1 per load miss
  - stat_writes, 16 bits: +1 per accepted store
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - WORD width
  - MEMDELAY
  - cache state enum (IDLE, MISS_RD, WR_THRU, RESP)
  - line struct (valid, tag, data)
  - index/tag extract functions parameterised by LINES
- One sub-module: cache_line_array. It holds the valid/tag/data storage with a combinational lookup (hit, data) and a synchronous write port, and implements the valid clear on reset.

Test Plan:
- Reset, then load 0x0010 with memory holding 0x1234 at delay 4 -> strobe held 4 cycles, rsp_valid 6 cycles after accept with 0x1234. A repeat load gives rsp_valid next cycle, no strobe.
- Store 0x0010 = 0xBEEF after the fill -> mem write with rnotw = 0 and wdata = 0xBEEF, ack with rsp_rdata = 0. A following load hits and returns 0xBEEF with no strobe.
- Conflict: load 0x0010 then 0x0018 (same index, LINES = 8), then 0x0010 -> three misses.
- Store to an uncached 0x0200, then load 0x0200 -> the load still misses (no allocate).
- Pid tagging: pid 1 load hit after pid 0 fill -> rsp_pid = 1 with the same data. req_valid held during a miss -> accepted only once req_ready = 1.
- Assert reset 2 cycles into MISS_RD -> strobe 0 immediately, no rsp_valid; the next load to the same address misses. With DATA_CACHE_STATS_EN, counters read 0 after reset.
